// File: rtl/logic_cluster.sv
// Logic cluster tile: NUM_BLE basic logic elements sharing a carry chain,
// configured through a serial scan chain that cascades to the next cluster.

// One BLE: two K-input LUTs, LUT-select mux, full adder and optional output register.
module logic_cluster_ble #(
  parameter int K = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*(2**K)+1:0] cfg_bits,     // LUT A, LUT B, adder_en, ff_en
  input  logic                ff_init_nxt,  // ff_init as it will be after this edge
  input  logic                init_load,
  input  logic                cap_en,
  input  logic [K-1:0]        lut_in,
  input  logic                lut_sel,
  input  logic                cin,
  output logic                cout,
  output logic                out_raw
);
  localparam int LS = 2**K;

  logic [LS-1:0] mem_a, mem_b;
  logic          a, b, adder_en, ff_en, sum, comb;
  logic          q_d, q_q;

  // LUT lookup, adder and output mux
  always_comb begin
    mem_a    = cfg_bits[LS-1:0];
    mem_b    = cfg_bits[2*LS-1:LS];
    adder_en = cfg_bits[2*LS];
    ff_en    = cfg_bits[2*LS+1];
    a        = mem_a[lut_in];
    b        = mem_b[lut_in];
    sum      = a ^ b ^ cin;
    cout     = (a & b) | (a & cin) | (b & cin);
    comb     = adder_en ? sum : (lut_sel ? b : a);
    out_raw  = ff_en ? q_q : comb;
  end

  // Register next value: init on config completion, capture when enabled, else hold
  always_comb begin
    q_d = q_q;
    if (init_load)   q_d = ff_init_nxt;
    else if (cap_en) q_d = comb;
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end
endmodule

// Cluster top: scan chain, load FSM, BLE array and output gating.
module logic_cluster #(
  parameter int K       = 3,
  parameter int NUM_BLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_shift_en,
  input  logic                 cfg_din,
  output logic                 cfg_dout,
  output logic                 cfg_done,
  input  logic                 ce,
  input  logic [NUM_BLE*K-1:0] lut_in,
  input  logic [NUM_BLE-1:0]   lut_sel,
  input  logic                 cin,
  output logic                 cout,
  output logic [NUM_BLE-1:0]   out
);
  localparam int BLE_BITS = 2*(2**K) + 3;
  localparam int CFG_BITS = NUM_BLE * BLE_BITS;
  localparam int CNT_W    = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {UNCFG = 2'd0, LOAD = 2'd1, ACTIVE = 2'd2} state_t;

  state_t               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [CFG_BITS-1:0]  cfg_d, cfg_q;
  logic                 init_load, active, cap_en;
  logic [NUM_BLE:0]     carry;
  logic [NUM_BLE-1:0]   out_raw;

  // Scan chain shifts toward bit 0; bits change only on shift cycles
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_shift_en) cfg_d = {cfg_din, cfg_q[CFG_BITS-1:1]};
  end

  // Load FSM next-state: count shifts until the whole chain is filled
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_load = 1'b0;
    case (state_q)
      UNCFG: if (cfg_shift_en) begin
        state_d = LOAD;
        cnt_d   = CNT_W'(1);
      end
      LOAD: if (cfg_shift_en) begin
        if (cnt_q == LAST) begin
          state_d   = ACTIVE;
          cnt_d     = '0;
          init_load = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE: if (cfg_shift_en) begin
        state_d = LOAD;
        cnt_d   = CNT_W'(1);
      end
      default: begin
        state_d = UNCFG;
        cnt_d   = '0;
      end
    endcase
  end

  // Config, FSM state and bit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      state_q <= UNCFG;
      cnt_q   <= '0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A shift takes priority over the clock enable
  always_comb begin
    active   = (state_q == ACTIVE);
    cap_en   = active & ~cfg_shift_en & ce;
    carry[0] = cin;
  end

  for (genvar g = 0; g < NUM_BLE; g++) begin : g_ble
    logic_cluster_ble #(.K(K)) u_ble (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_bits   (cfg_q[g*BLE_BITS +: BLE_BITS-1]),
      .ff_init_nxt(cfg_d[g*BLE_BITS + BLE_BITS-1]),
      .init_load  (init_load),
      .cap_en     (cap_en),
      .lut_in     (lut_in[g*K +: K]),
      .lut_sel    (lut_sel[g]),
      .cin        (carry[g]),
      .cout       (carry[g+1]),
      .out_raw    (out_raw[g])
    );
  end

  // Logic outputs are held low until configured; scan out is never gated
  always_comb begin
    cfg_dout = cfg_q[0];
    cfg_done = active;
    out      = active ? out_raw : '0;
    cout     = active & carry[NUM_BLE];
  end
endmodule

// File: tb/tb_logic_cluster.sv
// Testbench for logic_cluster (K=3, NUM_BLE=2): directed scenarios plus
// randomized traffic checked against a bit-level behavioural model.
module tb_logic_cluster;
  localparam int BB = 19;
  localparam int CB = 38;

  logic       clk = 1'b0;
  logic       rst_n, cfg_shift_en, cfg_din, ce, cin;
  logic [5:0] lut_in;
  logic [1:0] lut_sel, out;
  logic       cfg_dout, cfg_done, cout;

  int checks = 0;
  int errors = 0;

  // model state
  bit [CB-1:0] m_cfg;
  bit [1:0]    m_q;
  bit          m_active;
  int          m_nload;

  logic_cluster #(.K(3), .NUM_BLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_shift_en(cfg_shift_en), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .cfg_done(cfg_done), .ce(ce), .lut_in(lut_in),
    .lut_sel(lut_sel), .cin(cin), .cout(cout), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate LUTs and ripple-carry adder with integer arithmetic
  function automatic void m_eval(output bit [1:0] comb, output bit co);
    int c = int'(cin);
    for (int b = 0; b < 2; b++) begin
      int base = b * BB;
      int idx  = int'(lut_in[b*3 +: 3]);
      int a    = int'(m_cfg[base + idx]);
      int bv   = int'(m_cfg[base + 8 + idx]);
      int t    = a + bv + c;
      if (m_cfg[base + 16]) comb[b] = bit'(t % 2);
      else                  comb[b] = lut_sel[b] ? bit'(bv) : bit'(a);
      c = t / 2;
    end
    co = bit'(c);
  endfunction

  task automatic check_all();
    bit [1:0] comb, eo;
    bit co;
    m_eval(comb, co);
    for (int b = 0; b < 2; b++)
      eo[b] = m_active ? (m_cfg[b*BB + 17] ? m_q[b] : comb[b]) : 1'b0;
    chk("out", {6'b0, out}, {6'b0, eo});
    chk("cout", {7'b0, cout}, {7'b0, m_active & co});
    chk("cfg_done", {7'b0, cfg_done}, {7'b0, m_active});
    chk("cfg_dout", {7'b0, cfg_dout}, {7'b0, m_cfg[0]});
  endtask

  // One clock: model updates with the inputs held across the edge
  task automatic step(input bit sh, input bit din);
    bit [1:0] comb;
    bit co;
    cfg_shift_en = sh;
    cfg_din = din;
    m_eval(comb, co);
    @(posedge clk);
    if (sh) begin
      m_cfg = {din, m_cfg[CB-1:1]};
      if (m_active) begin
        m_active = 1'b0;
        m_nload  = 1;
      end else begin
        m_nload++;
        if (m_nload == CB) begin
          m_active = 1'b1;
          m_nload  = 0;
          m_q[0]   = m_cfg[18];
          m_q[1]   = m_cfg[BB + 18];
        end
      end
    end else if (m_active && ce) begin
      m_q = comb;
    end
    #1;
    check_all();
  endtask

  task automatic load_cfg(input bit [CB-1:0] c);
    for (int i = 0; i < CB; i++) step(1'b1, c[i]);
    cfg_shift_en = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    m_cfg = '0; m_q = '0; m_active = 1'b0; m_nload = 0;
    #1;
    check_all();
    chk("rst_cfg_dout", {7'b0, cfg_dout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit [BB-1:0] ble(input bit [7:0] la, input bit [7:0] lb,
                                      input bit ae, input bit fe, input bit fi);
    return {fi, fe, ae, lb, la};
  endfunction

  initial begin
    bit [CB-1:0] p;
    rst_n = 1'b0; cfg_shift_en = 1'b0; cfg_din = 1'b0; ce = 1'b0; cin = 1'b0;
    lut_in = '0; lut_sel = '0;
    m_cfg = '0; m_q = '0; m_active = 1'b0; m_nload = 0;
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset in the middle of a load, then a full load
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom));
    do_reset();
    p = {ble(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0), ble(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0)};
    load_cfg(p);
    chk("t1_done", {7'b0, cfg_done}, 8'h01);

    // 2: pure combinational LUT A path
    load_cfg({ble(8'h00, 8'h00, 1'b0, 1'b0, 1'b0), ble(8'h96, 8'h00, 1'b0, 1'b0, 1'b0)});
    lut_sel = 2'b00; lut_in = 6'b000_011; #1;
    chk("t2_lut3", {7'b0, out[0]}, 8'h00);
    check_all();
    lut_in = 6'b000_111; #1;
    chk("t2_lut7", {7'b0, out[0]}, 8'h01);
    check_all();

    // 3: adder chain across both BLEs
    load_cfg({ble(8'hF0, 8'hCC, 1'b1, 1'b0, 1'b0), ble(8'hF0, 8'hCC, 1'b1, 1'b0, 1'b0)});
    cin = 1'b1; lut_in = 6'b000_110; #1;
    chk("t3_out", {6'b0, out}, 8'h03);
    chk("t3_cout", {7'b0, cout}, 8'h00);
    check_all();

    // 4: registered output initialised from ff_init, then captures
    ce = 1'b0; cin = 1'b0; lut_in = '0;
    load_cfg({ble(8'h00, 8'h00, 1'b0, 1'b1, 1'b1), ble(8'h00, 8'h00, 1'b0, 1'b0, 1'b0)});
    chk("t4_init", {7'b0, out[1]}, 8'h01);
    step(1'b0, 1'b0);
    chk("t4_hold", {7'b0, out[1]}, 8'h01);
    ce = 1'b1; #1;
    chk("t4_pre", {7'b0, out[1]}, 8'h01);
    step(1'b0, 1'b0);
    chk("t4_cap", {7'b0, out[1]}, 8'h00);

    // 5: a shift while active drops back to loading
    lut_in = 6'b111_111; lut_sel = 2'b11;
    step(1'b1, 1'b1);
    chk("t5_done0", {7'b0, cfg_done}, 8'h00);
    chk("t5_out0", {6'b0, out}, 8'h00);
    for (int i = 0; i < CB - 1; i++) step(1'b1, 1'($urandom));
    cfg_shift_en = 1'b0;
    chk("t5_done1", {7'b0, cfg_done}, 8'h01);

    // 6: scan-out replays the loaded pattern
    p = {$urandom, $urandom};
    load_cfg(p);
    for (int i = 0; i < CB; i++) begin
      chk("t6_dout", {7'b0, cfg_dout}, {7'b0, p[i]});
      step(1'b1, 1'b0);
    end
    cfg_shift_en = 1'b0;

    // randomized configurations and traffic
    for (int r = 0; r < 6; r++) begin
      load_cfg({$urandom, $urandom});
      for (int i = 0; i < 60; i++) begin
        lut_in = 6'($urandom); lut_sel = 2'($urandom); cin = 1'($urandom);
        ce = 1'($urandom);
        step($urandom_range(0, 9) == 0, 1'($urandom));
      end
      cfg_shift_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
